// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg -- arbitration mode encodings and select-width helper shared by the mux family.
// Rev 1.0
`default_nettype none

package rr_stream_mux_pkg;

  localparam int MUX_MODE_RR    = 0;
  localparam int MUX_MODE_FIXED = 1;

  // Index width for n channels, never below one bit so a 1-channel mux still has a port.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter -- one-hot round-robin / fixed-priority grant generator owning the rotation pointer.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int MODE   = MUX_MODE_RR,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] start;
  logic             found;
  int               idx;

  // Fixed priority is a round-robin search that always starts at channel 0.
  assign start = (MODE == MUX_MODE_RR) ? rr_ptr : '0;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = int'(start) + off;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && (i == idx) && req[i]) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
  end

  // Wrap against NUM_CH-1 so a non-power-of-two count never points past the last channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && (MODE == MUX_MODE_RR)) begin
      rr_ptr <= (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// rr_stream_mux -- merges NUM_CH valid/ready streams into one registered stream, one cycle latency.
// Rev 1.0
`default_nettype none

module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 2,
  parameter  int MODE   = MUX_MODE_RR,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
);

  logic              load;
  logic              any_valid;
  logic              advance;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  sel_data;

  assign load      = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // Reset gates the handshake so no source sees an accept while the register is held clear.
  assign advance  = load && any_valid && !rst;
  assign in_ready = gnt & {NUM_CH{load && !rst}};

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (advance),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is one-hot, so a flat AND-OR select keeps the data path free of priority logic.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_data <= sel_data;
        out_sel  <= gnt_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux -- directed checks of rr_stream_mux across four parameter sets.
// Rev 1.0
`default_nettype none

module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: 4 channels round-robin
  logic [3:0]  in_valid_a, in_ready_a;
  logic [31:0] in_data_a;
  logic        out_valid_a, out_ready_a;
  logic [7:0]  out_data_a;
  logic [1:0]  out_sel_a;
  // B: 3 channels fixed priority
  logic [2:0]  in_valid_b, in_ready_b;
  logic [23:0] in_data_b;
  logic        out_valid_b, out_ready_b;
  logic [7:0]  out_data_b;
  logic [1:0]  out_sel_b;
  // C: 3 channels round-robin
  logic [2:0]  in_valid_c, in_ready_c;
  logic [23:0] in_data_c;
  logic        out_valid_c, out_ready_c;
  logic [7:0]  out_data_c;
  logic [1:0]  out_sel_c;
  // D: 1 channel, 16-bit
  logic [0:0]  in_valid_d, in_ready_d;
  logic [15:0] in_data_d;
  logic        out_valid_d, out_ready_d;
  logic [15:0] out_data_d;
  logic [0:0]  out_sel_d;

  rr_stream_mux #(.WIDTH(8), .NUM_CH(4), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_sel(out_sel_a));
  rr_stream_mux #(.WIDTH(8), .NUM_CH(3), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_sel(out_sel_b));
  rr_stream_mux #(.WIDTH(8), .NUM_CH(3), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_data(in_data_c), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c), .out_sel(out_sel_c));
  rr_stream_mux #(.WIDTH(16), .NUM_CH(1), .MODE(0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_data(in_data_d), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d), .out_sel(out_sel_d));

  int errors = 0;
  int checks = 0;
  int exp_sel[6] = '{0, 1, 2, 3, 0, 1};
  int exp_dat[6] = '{'h10, 'h11, 'h12, 'h13, 'h10, 'h11};
  int sent, recv;
  logic acc_in, acc_out;
  logic [15:0] popped;
  logic [0:0]  popped_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = '0; in_data_a = '0; out_ready_a = 1'b0;
    in_valid_b = '0; in_data_b = '0; out_ready_b = 1'b0;
    in_valid_c = '0; in_data_c = '0; out_ready_c = 1'b0;
    in_valid_d = '0; in_data_d = '0; out_ready_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_data", out_data_a, 0);
    chk("rst_sel", out_sel_a, 0);
    chk("rst_ready", in_ready_a, 0);
    rst = 1'b0;

    // Round-robin fairness with all channels valid and no backpressure
    in_valid_a = 4'hF; in_data_a = 32'h13121110; out_ready_a = 1'b1;
    #1;
    chk("rr_first_ready", in_ready_a, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_valid", out_valid_a, 1);
      chk("rr_sel", out_sel_a, exp_sel[k]);
      chk("rr_data", out_data_a, exp_dat[k]);
    end

    // Mid-stream reset clears the register at once and blocks all accepts
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_sel", out_sel_a, 0);
    chk("mid_rst_data", out_data_a, 0);
    chk("mid_rst_ready", in_ready_a, 0);
    tick();
    chk("mid_rst_hold_valid", out_valid_a, 0);
    chk("mid_rst_hold_ready", in_ready_a, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready_a, 4'b0001);
    tick();
    chk("post_rst_sel", out_sel_a, 0);
    chk("post_rst_data", out_data_a, 8'h10);

    // Backpressure: ch1 word must stay put, then the pointer resumes at ch2
    in_valid_a = 4'b0010; in_data_a = 32'h1312A510;
    #1;
    chk("bp_ready_ch1", in_ready_a, 4'b0010);
    tick();
    chk("bp_load_data", out_data_a, 8'hA5);
    chk("bp_load_sel", out_sel_a, 1);
    in_valid_a = 4'hF; in_data_a = 32'h13121110; out_ready_a = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_stall_ready", in_ready_a, 0);
      tick();
      chk("bp_stall_valid", out_valid_a, 1);
      chk("bp_stall_data", out_data_a, 8'hA5);
      chk("bp_stall_sel", out_sel_a, 1);
    end
    out_ready_a = 1'b1;
    #1;
    chk("bp_release_ready", in_ready_a, 4'b0100);
    tick();
    chk("bp_release_sel", out_sel_a, 2);
    chk("bp_release_data", out_data_a, 8'h12);
    in_valid_a = '0;

    // Fixed priority: ch0 always wins over ch2 until it drops
    in_valid_b = 3'b101; in_data_b = 24'h222120; out_ready_b = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("fix_ready", in_ready_b, 3'b001);
      tick();
      chk("fix_sel", out_sel_b, 0);
      chk("fix_data", out_data_b, 8'h20);
    end
    in_valid_b = 3'b100;
    #1;
    chk("fix_drop_ready", in_ready_b, 3'b100);
    tick();
    chk("fix_drop_sel", out_sel_b, 2);
    chk("fix_drop_data", out_data_b, 8'h22);
    in_valid_b = '0;

    // Sparse traffic: lone ch2 grant, pointer wraps past the last channel to 0
    in_valid_c = 3'b100; in_data_c = 24'h333231; out_ready_c = 1'b1;
    #1;
    chk("sparse_ready", in_ready_c, 3'b100);
    tick();
    chk("sparse_valid", out_valid_c, 1);
    chk("sparse_sel", out_sel_c, 2);
    chk("sparse_data", out_data_c, 8'h33);
    in_valid_c = '0;
    #1;
    chk("sparse_idle_ready", in_ready_c, 0);
    tick();
    chk("sparse_idle_valid", out_valid_c, 0);
    chk("sparse_idle_sel", out_sel_c, 2);
    chk("sparse_idle_data", out_data_c, 8'h33);
    in_valid_c = 3'b111;
    #1;
    chk("sparse_wrap_ready", in_ready_c, 3'b001);
    tick();
    chk("sparse_wrap_sel", out_sel_c, 0);
    chk("sparse_wrap_data", out_data_c, 8'h31);
    in_valid_c = '0;

    // Single channel stream under random backpressure, checked against arrival order
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
      out_ready_d = 1'($urandom_range(0, 1));
      in_valid_d  = 1'(sent < 16);
      in_data_d   = 16'(sent + 1);
      #1;
      acc_in     = in_valid_d[0] & in_ready_d[0];
      acc_out    = out_valid_d & out_ready_d;
      popped     = out_data_d;
      popped_sel = out_sel_d;
      tick();
      if (acc_in) sent++;
      if (acc_out) begin
        chk("sb_data", popped, recv + 1);
        chk("sb_sel", popped_sel, 0);
        recv++;
      end
    end
    chk("sb_count", recv, 16);
    in_valid_d = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
